job_scheduler: RTL and testbench
================================

Name: job_scheduler

Overview:
- Hash-clock-domain job sequencer between the comm front end and the hashing core.
- Holds the active job and one queued job, and issues new-work pulses to the core.
- Auto-promotes the queued job when the core exhausts its nonce range.
- Buffers golden nonces and status events into a single valid/ready event stream for the UART message encoder (NONCE_FOUND, QUEUED_JOB_STARTED, NONCERANGE_EXHAUSTED).

Parameters:
- JOB_SIZE, 416: job word width; fields MSB-first are midstate[255:0], data[95:0], noncemin[31:0], noncemax[31:0].
- NONCE_FIFO_DEPTH, 8: golden-nonce FIFO entries; power of two, minimum 2.
- MSG_NONCE_FOUND, 8'd6: event type code.
- MSG_QUEUED_JOB_STARTED, 8'd7: event type code.
- MSG_NONCERANGE_EXHAUSTED, 8'd8: event type code.

Ports:
- clk  in  1  single clock (hash clock).
- reset  in  1  synchronous, active-high reset.
- push_we  in  1  one-cycle strobe: replace the active job with job_in.
- queue_we  in  1  one-cycle strobe: write job_in to the queue slot.
- job_in  in  JOB_SIZE  job word for push_we/queue_we.
- need_work  in  1  core level/strobe: current nonce range exhausted.
- new_nonce  in  1  core strobe: golden_nonce is valid.
- golden_nonce  in  32  nonce found by the core.
- tx_new_work  out  1  one-cycle pulse: job outputs carry a new job.
- tx_midstate  out  256  active job midstate.
- tx_data  out  96  active job data.
- tx_noncemin  out  32  active job nonce start.
- tx_noncemax  out  32  active job nonce end.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts the event when evt_valid & evt_ready.
- evt_type  out  8  event type code.
- evt_payload  out  32  nonce for NONCE_FOUND, else 0.
- busy  out  1  state == RUN.
- queued_valid  out  1  queue slot occupied.
- nonce_drop_count  out  8  saturating count of nonces dropped on full FIFO.

Behaviour:
Reset (synchronous, checked first every edge):
- State IDLE; all outputs 0; active job, queue slot, FIFO and pending flags cleared.

State machine (IDLE, RUN), evaluated per cycle in priority order:
- push_we (any state):
  - active job <= job_in; state RUN; queued_valid <= 0.
  - If queue_we is also asserted: queue slot <= job_in, queued_valid <= 1.
  - need_work is ignored this cycle.
- RUN, need_work=1, queued_valid=1 (no push):
  - active job <= queue slot; queued_valid <= 0; set pending_started.
  - A same-cycle queue_we writes the slot after promotion, so queued_valid ends at 1.
- RUN, need_work=1, queued_valid=0:
  - state IDLE; set pending_exhausted.
  - A same-cycle queue_we fills the slot; it is promoted next cycle by the IDLE rule.
- IDLE, queued_valid=1 (no push):
  - Promote as above; state RUN; set pending_started.
- IDLE, need_work: ignored.
- queue_we otherwise: slot <= job_in, queued_valid <= 1; overwrites an occupied slot silently.

Job output timing:
- Every load/promotion updates the tx_* job fields and pulses tx_new_work on the same following edge, so latency is 1 cycle from the strobe or need_work.
- The tx_* job fields are held stable between loads.
- Back-to-back loads produce back-to-back pulses.

Nonce FIFO:
- new_nonce with FIFO not full: enqueue golden_nonce.
- new_nonce with FIFO full: drop it; nonce_drop_count += 1, saturating at 255.
- Simultaneous enqueue and dequeue on a full FIFO is allowed: the dequeue frees the slot.
- The FIFO is not flushed on job change.

Event arbiter:
- Fixed priority: pending_exhausted, then pending_started, then FIFO head.
- Pending flags are single bits; repeated sets while pending coalesce into one event.
- evt_valid, evt_type and evt_payload are registered and held stable until the handshake.
- A higher-priority event arriving while a lower one is presented does not preempt it.
- On handshake:
  - Clear the presented flag, or pop the FIFO.
  - The next event may present on the following cycle, giving at most 1 event per 2 cycles.
  - Back-to-back events (1 per cycle) are also acceptable.
  - evt_valid may not drop without a handshake.
- A flag set in the same cycle as its own event's handshake stays set and re-presents.

Test Plan:
- Reset, then push_we with job_in = {256'h11.., 96'h22.., 32'h0, 32'hFFFF_FFFF} -> tx_new_work high exactly 1 cycle after; tx_noncemax = FFFF_FFFF; busy = 1; no event.
- Push A, queue B, need_work pulse -> tx_new_work pulse with B fields; queued_valid 0; event type 7, payload 0.
- RUN with empty queue, need_work -> busy 0; event type 8. Then queue_we C -> C promoted 1 cycle later, tx_new_work pulse, event type 7.
- evt_ready held 0, 10 new_nonce strobes with values 1..10 (depth 8) -> nonce_drop_count = 2. Then evt_ready = 1 -> type 6 events with payloads 1..8 in order, evt_valid then 0.
- Same cycle push_we and need_work with queue occupied -> push job loaded, queued_valid 0, no type 7/8 events. Same cycle push_we and queue_we -> queued_valid 1.
- Reset asserted mid-stream with evt_valid high and FIFO non-empty -> next cycle all outputs 0, busy 0, FIFO empty, nonce_drop_count 0.

Source files
------------

// File: rtl/job_scheduler_if.sv
// Comm-side bus of the job scheduler: job loads, core strobes, event stream and status.
interface job_scheduler_if #(
    parameter int unsigned JOB_SIZE = 416
);
    logic                push_we;
    logic                queue_we;
    logic [JOB_SIZE-1:0] job_in;
    logic                need_work;
    logic                new_nonce;
    logic [31:0]         golden_nonce;
    logic                tx_new_work;
    logic [255:0]        tx_midstate;
    logic [95:0]         tx_data;
    logic [31:0]         tx_noncemin;
    logic [31:0]         tx_noncemax;
    logic                evt_valid;
    logic                evt_ready;
    logic [7:0]          evt_type;
    logic [31:0]         evt_payload;
    logic                busy;
    logic                queued_valid;
    logic [7:0]          nonce_drop_count;

    // Front end / core / encoder side
    modport master (
        output push_we, queue_we, job_in, need_work, new_nonce, golden_nonce, evt_ready,
        input  tx_new_work, tx_midstate, tx_data, tx_noncemin, tx_noncemax,
               evt_valid, evt_type, evt_payload, busy, queued_valid, nonce_drop_count
    );

    // Scheduler side
    modport slave (
        input  push_we, queue_we, job_in, need_work, new_nonce, golden_nonce, evt_ready,
        output tx_new_work, tx_midstate, tx_data, tx_noncemin, tx_noncemax,
               evt_valid, evt_type, evt_payload, busy, queued_valid, nonce_drop_count
    );
endinterface

// File: rtl/job_scheduler.sv
// Job sequencer: active job + one queued job, auto-promotion, and an event stream
// merging range-exhausted / queued-job-started flags with buffered golden nonces.
module job_scheduler #(
    parameter int unsigned JOB_SIZE                 = 416,
    parameter int unsigned NONCE_FIFO_DEPTH         = 8,
    parameter logic [7:0]  MSG_NONCE_FOUND          = 8'd6,
    parameter logic [7:0]  MSG_QUEUED_JOB_STARTED   = 8'd7,
    parameter logic [7:0]  MSG_NONCERANGE_EXHAUSTED = 8'd8
) (
    input  logic          clk,
    input  logic          reset,
    job_scheduler_if.slave bus
);
    localparam int unsigned AW = $clog2(NONCE_FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [1:0] SRC_EXH     = 2'd0;
    localparam logic [1:0] SRC_STARTED = 2'd1;
    localparam logic [1:0] SRC_NONCE   = 2'd2;

    logic [0:0]          state_q, state_d;
    logic [JOB_SIZE-1:0] job_q, job_d;
    logic [JOB_SIZE-1:0] slot_q, slot_d;
    logic                qv_q, qv_d;
    logic                new_work_q, new_work_d;
    logic                pend_exh_q, pend_exh_d;
    logic                pend_started_q, pend_started_d;
    logic                set_exh, set_started;

    logic [31:0]         fifo_mem [NONCE_FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]       fifo_count;
    logic                fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [7:0]          drop_q, drop_d;

    logic                evt_valid_q, evt_valid_d;
    logic [7:0]          evt_type_q, evt_type_d;
    logic [31:0]         evt_payload_q, evt_payload_d;
    logic [1:0]          evt_src_q, evt_src_d;
    logic                hs;

    // Job FSM: push has top priority, then need_work handling, then idle promotion, then queue writes
    always_comb begin
        state_d     = state_q;
        job_d       = job_q;
        slot_d      = slot_q;
        qv_d        = qv_q;
        new_work_d  = 1'b0;
        set_exh     = 1'b0;
        set_started = 1'b0;
        if (bus.push_we) begin
            job_d      = bus.job_in;
            state_d    = ST_RUN;
            new_work_d = 1'b1;
            qv_d       = 1'b0;
            if (bus.queue_we) begin
                slot_d = bus.job_in;
                qv_d   = 1'b1;
            end
        end else begin
            if (bus.need_work && state_q == ST_RUN) begin
                if (qv_q) begin
                    job_d       = slot_q;
                    qv_d        = 1'b0;
                    new_work_d  = 1'b1;
                    set_started = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    set_exh = 1'b1;
                end
            end else if (state_q == ST_IDLE && qv_q) begin
                job_d       = slot_q;
                qv_d        = 1'b0;
                new_work_d  = 1'b1;
                set_started = 1'b1;
                state_d     = ST_RUN;
            end
            // A queue write lands after any promotion in the same cycle
            if (bus.queue_we) begin
                slot_d = bus.job_in;
                qv_d   = 1'b1;
            end
        end
    end

    // Event arbiter, pending flags and nonce FIFO pointers
    always_comb begin
        hs             = evt_valid_q & bus.evt_ready;
        fifo_count     = wr_ptr_q - rd_ptr_q;
        fifo_full      = (fifo_count == PW'(NONCE_FIFO_DEPTH));
        fifo_empty     = (fifo_count == '0);
        fifo_pop       = hs && (evt_src_q == SRC_NONCE);
        fifo_push      = bus.new_nonce && (!fifo_full || fifo_pop);
        wr_ptr_d       = wr_ptr_q + PW'(fifo_push);
        rd_ptr_d       = rd_ptr_q + PW'(fifo_pop);
        drop_d         = drop_q;
        if (bus.new_nonce && !fifo_push && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end
        // A set in the handshake cycle wins over the clear, so the event re-presents
        pend_exh_d     = (pend_exh_q && !(hs && evt_src_q == SRC_EXH)) || set_exh;
        pend_started_d = (pend_started_q && !(hs && evt_src_q == SRC_STARTED)) || set_started;
        evt_valid_d    = evt_valid_q;
        evt_type_d     = evt_type_q;
        evt_payload_d  = evt_payload_q;
        evt_src_d      = evt_src_q;
        if (hs) begin
            evt_valid_d = 1'b0;
        end else if (!evt_valid_q) begin
            if (pend_exh_q) begin
                evt_valid_d   = 1'b1;
                evt_type_d    = MSG_NONCERANGE_EXHAUSTED;
                evt_payload_d = 32'd0;
                evt_src_d     = SRC_EXH;
            end else if (pend_started_q) begin
                evt_valid_d   = 1'b1;
                evt_type_d    = MSG_QUEUED_JOB_STARTED;
                evt_payload_d = 32'd0;
                evt_src_d     = SRC_STARTED;
            end else if (!fifo_empty) begin
                evt_valid_d   = 1'b1;
                evt_type_d    = MSG_NONCE_FOUND;
                evt_payload_d = fifo_mem[rd_ptr_q[AW-1:0]];
                evt_src_d     = SRC_NONCE;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            job_q          <= '0;
            slot_q         <= '0;
            qv_q           <= 1'b0;
            new_work_q     <= 1'b0;
            pend_exh_q     <= 1'b0;
            pend_started_q <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            drop_q         <= '0;
            evt_valid_q    <= 1'b0;
            evt_type_q     <= '0;
            evt_payload_q  <= '0;
            evt_src_q      <= SRC_EXH;
        end else begin
            state_q        <= state_d;
            job_q          <= job_d;
            slot_q         <= slot_d;
            qv_q           <= qv_d;
            new_work_q     <= new_work_d;
            pend_exh_q     <= pend_exh_d;
            pend_started_q <= pend_started_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            drop_q         <= drop_d;
            evt_valid_q    <= evt_valid_d;
            evt_type_q     <= evt_type_d;
            evt_payload_q  <= evt_payload_d;
            evt_src_q      <= evt_src_d;
        end
    end

    // Nonce storage; contents need no reset since the pointers gate visibility
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= bus.golden_nonce;
        end
    end

    assign bus.tx_new_work      = new_work_q;
    assign bus.tx_midstate      = job_q[JOB_SIZE-1 -: 256];
    assign bus.tx_data          = job_q[JOB_SIZE-257 -: 96];
    assign bus.tx_noncemin      = job_q[63:32];
    assign bus.tx_noncemax      = job_q[31:0];
    assign bus.evt_valid        = evt_valid_q;
    assign bus.evt_type         = evt_type_q;
    assign bus.evt_payload      = evt_payload_q;
    assign bus.busy             = (state_q == ST_RUN);
    assign bus.queued_valid     = qv_q;
    assign bus.nonce_drop_count = drop_q;
endmodule

// File: tb/tb_job_scheduler.sv
// Directed bench for job_scheduler: per-cycle vector table plus nonce-FIFO and reset sequences.
module tb_job_scheduler;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    job_scheduler_if #(.JOB_SIZE(416)) bus();

    job_scheduler #(
        .JOB_SIZE(416),
        .NONCE_FIFO_DEPTH(8),
        .MSG_NONCE_FOUND(8'd6),
        .MSG_QUEUED_JOB_STARTED(8'd7),
        .MSG_NONCERANGE_EXHAUSTED(8'd8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        logic       push;
        logic       queue;
        logic       need;
        int         jsel;
        logic       ready;
        logic       e_nw;
        logic       e_busy;
        logic       e_qv;
        logic       e_ev;
        logic [7:0] e_type;
        int         e_job;
    } vec_t;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [415:0] jobs [4];
    logic [415:0] tx_job;
    vec_t         vecs [20];
    int           got_n;
    logic [7:0]   got_type [8];
    logic [31:0]  got_pay [8];

    assign tx_job = {bus.tx_midstate, bus.tx_data, bus.tx_noncemin, bus.tx_noncemax};

    task automatic chk(input string name, input logic [415:0] act, input logic [415:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic p, input logic q, input logic n, input int js,
                                input logic r, input logic nw, input logic b, input logic qv,
                                input logic ev, input logic [7:0] ty, input int ej);
        vec_t v;
        v.push = p; v.queue = q; v.need = n; v.jsel = js; v.ready = r;
        v.e_nw = nw; v.e_busy = b; v.e_qv = qv; v.e_ev = ev; v.e_type = ty; v.e_job = ej;
        return v;
    endfunction

    task automatic idle_inputs();
        bus.push_we      = 1'b0;
        bus.queue_we     = 1'b0;
        bus.need_work    = 1'b0;
        bus.new_nonce    = 1'b0;
        bus.golden_nonce = 32'd0;
        bus.job_in       = '0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_tx_job"}, tx_job, '0);
        chk({tag, "_nw"}, 416'(bus.tx_new_work), '0);
        chk({tag, "_evt_valid"}, 416'(bus.evt_valid), '0);
        chk({tag, "_evt_type"}, 416'(bus.evt_type), '0);
        chk({tag, "_evt_payload"}, 416'(bus.evt_payload), '0);
        chk({tag, "_busy"}, 416'(bus.busy), '0);
        chk({tag, "_qv"}, 416'(bus.queued_valid), '0);
        chk({tag, "_drops"}, 416'(bus.nonce_drop_count), '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        jobs[0] = {{32{8'h11}}, {12{8'h22}}, 32'h0000_0000, 32'hFFFF_FFFF};
        jobs[1] = {{32{8'h33}}, {12{8'h44}}, 32'h0000_1000, 32'h0000_1FFF};
        jobs[2] = {{32{8'h55}}, {12{8'h66}}, 32'h0000_2000, 32'h0000_2FFF};
        jobs[3] = {{32{8'h77}}, {12{8'h88}}, 32'h0000_3000, 32'h0000_3FFF};

        //             push q need js rdy  nw busy qv ev type job
        vecs[0]  = mk(1, 0, 0, 0, 0,   1, 1, 0, 0, 8'd0, 0);  // load A
        vecs[1]  = mk(0, 0, 0, 0, 0,   0, 1, 0, 0, 8'd0, 0);  // pulse is one cycle, fields held
        vecs[2]  = mk(0, 1, 0, 1, 0,   0, 1, 1, 0, 8'd0, 0);  // queue B
        vecs[3]  = mk(0, 0, 1, 0, 0,   1, 1, 0, 0, 8'd0, 1);  // need_work promotes B
        vecs[4]  = mk(0, 0, 0, 0, 0,   0, 1, 0, 1, 8'd7, 1);  // started event presents
        vecs[5]  = mk(0, 0, 0, 0, 0,   0, 1, 0, 1, 8'd7, 1);  // held without ready
        vecs[6]  = mk(0, 0, 0, 0, 1,   0, 1, 0, 0, 8'd0, 1);  // handshake
        vecs[7]  = mk(0, 0, 1, 0, 1,   0, 0, 0, 0, 8'd0, 1);  // exhausted, empty queue -> IDLE
        vecs[8]  = mk(0, 1, 0, 2, 0,   0, 0, 1, 1, 8'd8, 1);  // queue C; exhausted event
        vecs[9]  = mk(0, 0, 0, 0, 1,   1, 1, 0, 0, 8'd0, 2);  // idle promotes C; handshake
        vecs[10] = mk(0, 0, 0, 0, 1,   0, 1, 0, 1, 8'd7, 2);  // started event
        vecs[11] = mk(0, 0, 0, 0, 1,   0, 1, 0, 0, 8'd0, 2);  // handshake
        vecs[12] = mk(0, 1, 0, 3, 1,   0, 1, 1, 0, 8'd0, 2);  // queue D
        vecs[13] = mk(1, 0, 1, 0, 1,   1, 1, 0, 0, 8'd0, 0);  // push + need_work: push wins
        vecs[14] = mk(0, 0, 0, 0, 1,   0, 1, 0, 0, 8'd0, 0);  // no event from that
        vecs[15] = mk(1, 1, 0, 1, 1,   1, 1, 1, 0, 8'd0, 1);  // push + queue same word
        vecs[16] = mk(0, 0, 0, 0, 1,   0, 1, 1, 0, 8'd0, 1);
        vecs[17] = mk(1, 0, 0, 2, 1,   1, 1, 0, 0, 8'd0, 2);  // back-to-back loads
        vecs[18] = mk(1, 0, 0, 0, 1,   1, 1, 0, 0, 8'd0, 0);
        vecs[19] = mk(0, 0, 0, 0, 1,   0, 1, 0, 0, 8'd0, 0);

        reset = 1'b1;
        bus.evt_ready = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            idle_inputs();
            bus.push_we   = vecs[i].push;
            bus.queue_we  = vecs[i].queue;
            bus.need_work = vecs[i].need;
            bus.job_in    = jobs[vecs[i].jsel];
            bus.evt_ready = vecs[i].ready;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_nw", i), 416'(bus.tx_new_work), 416'(vecs[i].e_nw));
            chk($sformatf("row%0d_busy", i), 416'(bus.busy), 416'(vecs[i].e_busy));
            chk($sformatf("row%0d_qv", i), 416'(bus.queued_valid), 416'(vecs[i].e_qv));
            chk($sformatf("row%0d_evt_valid", i), 416'(bus.evt_valid), 416'(vecs[i].e_ev));
            chk($sformatf("row%0d_job", i), tx_job, jobs[vecs[i].e_job]);
            if (vecs[i].e_ev) begin
                chk($sformatf("row%0d_evt_type", i), 416'(bus.evt_type), 416'(vecs[i].e_type));
                chk($sformatf("row%0d_evt_payload", i), 416'(bus.evt_payload), '0);
            end
        end

        // Ten nonces into an 8-deep FIFO with the consumer stalled
        @(negedge clk);
        idle_inputs();
        bus.evt_ready = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            bus.new_nonce    = 1'b1;
            bus.golden_nonce = 32'(k);
            @(negedge clk);
        end
        idle_inputs();
        @(posedge clk);
        #1;
        chk("fifo_drops", 416'(bus.nonce_drop_count), 416'(2));
        chk("fifo_head_valid", 416'(bus.evt_valid), 416'(1));
        chk("fifo_head_type", 416'(bus.evt_type), 416'(6));
        chk("fifo_head_payload", 416'(bus.evt_payload), 416'(1));

        @(negedge clk);
        bus.evt_ready = 1'b1;
        got_n = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.evt_valid) begin
                if (got_n < 8) begin
                    got_type[got_n] = bus.evt_type;
                    got_pay[got_n]  = bus.evt_payload;
                end
                got_n++;
            end
            @(negedge clk);
        end
        chk("drain_count", 416'(got_n), 416'(8));
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("drain%0d_type", k), 416'(got_type[k]), 416'(6));
            chk($sformatf("drain%0d_payload", k), 416'(got_pay[k]), 416'(k + 1));
        end
        chk("drain_empty", 416'(bus.evt_valid), '0);

        // Reset in the middle of a stalled event stream
        bus.evt_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.new_nonce    = 1'b1;
            bus.golden_nonce = 32'hA1 + 32'(k);
            @(negedge clk);
        end
        idle_inputs();
        @(negedge clk);
        chk("pre_reset_valid", 416'(bus.evt_valid), 416'(1));
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        reset = 1'b0;
        bus.evt_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_reset_fifo_empty", 416'(bus.evt_valid), '0);

        // need_work while idle is ignored
        bus.need_work = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_need_busy", 416'(bus.busy), '0);
        chk("idle_need_nw", 416'(bus.tx_new_work), '0);
        @(negedge clk);
        bus.need_work = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_need_no_event", 416'(bus.evt_valid), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
